// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC field write sequencer: state codes, field indices
// and the one-hot mux select patterns.
package rtc_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SCAN   = 3'd1;
    localparam state_t ST_SETTLE = 3'd2;
    localparam state_t ST_REQ    = 3'd3;
    localparam state_t ST_FIN    = 3'd4;

    localparam logic [2:0] FLD_A = 3'd0;
    localparam logic [2:0] FLD_B = 3'd1;
    localparam logic [2:0] FLD_C = 3'd2;
    localparam logic [2:0] FLD_D = 3'd3;
    localparam logic [2:0] FLD_E = 3'd4;
    localparam logic [2:0] FLD_F = 3'd5;

    localparam logic [5:0] SEL_NONE = 6'b000000;
    localparam logic [5:0] SEL_A    = 6'b100000;
    localparam logic [5:0] SEL_B    = 6'b010000;
    localparam logic [5:0] SEL_C    = 6'b001000;
    localparam logic [5:0] SEL_D    = 6'b000100;
    localparam logic [5:0] SEL_E    = 6'b000010;
    localparam logic [5:0] SEL_F    = 6'b000001;

    localparam logic [7:0] RTC_BASE_ADDR_DEFAULT = 8'h00;

    // Field A sits on the MSB of the select, so later fields shift right.
    function automatic logic [5:0] fld_sel(input logic [2:0] idx);
        fld_sel = SEL_A >> idx;
    endfunction

endpackage

// File: rtl/rtc_field_write_seq.sv
// Steps through the enabled RTC time/date fields A..F, driving the byte-mux select and
// register address and handshaking one write per field. `RTC_WSEQ_TIMEOUT_EN adds an ack timeout.
module rtc_field_write_seq
    import rtc_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR      = RTC_BASE_ADDR_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] field_mask,
    output logic [5:0] sel,
    output logic [7:0] addr,
    output logic       wr_req,
    input  logic       wr_ack,
    output logic       busy,
    output logic       done
`ifdef RTC_WSEQ_TIMEOUT_EN
    ,
    output logic       err
`endif
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 16-bit ack counter");
    end

    state_t     state;
    logic [5:0] mask_q;
    logic [2:0] idx;
    logic       timeout;

`ifdef RTC_WSEQ_TIMEOUT_EN
    logic [15:0] ack_cnt;

    assign timeout = (state == ST_REQ) && !wr_ack
                     && (ack_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Counter restarts on every entry to REQ; err persists until the next accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (state == ST_SETTLE) begin
                ack_cnt <= '0;
            end else if (state == ST_REQ) begin
                ack_cnt <= ack_cnt + 16'd1;
            end
            if (state == ST_IDLE && start) begin
                err <= 1'b0;
            end else if (timeout) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            mask_q <= '0;
            idx    <= FLD_A;
            sel    <= SEL_NONE;
            addr   <= BASE_ADDR;
            wr_req <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sel <= SEL_NONE;
                    if (start) begin
                        mask_q <= field_mask;
                        idx    <= FLD_A;
                        busy   <= 1'b1;
                        state  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // mask bit 5 belongs to field A, so index from the top.
                    if (mask_q[3'd5 - idx]) begin
                        sel   <= fld_sel(idx);
                        addr  <= BASE_ADDR + {5'd0, idx};
                        state <= ST_SETTLE;
                    end else if (idx == FLD_F) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        sel   <= SEL_NONE;
                        state <= ST_FIN;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                ST_SETTLE: begin
                    wr_req <= 1'b1;
                    state  <= ST_REQ;
                end
                ST_REQ: begin
                    if (wr_ack || timeout) begin
                        wr_req <= 1'b0;
                        if (idx == FLD_F || timeout) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            sel   <= SEL_NONE;
                            state <= ST_FIN;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_field_write_seq.sv
// Bench for rtc_field_write_seq: table vectors, randomized runs against a field-list model,
// and hand sequences for reset-during-write and (with RTC_WSEQ_TIMEOUT_EN) the ack timeout.
module tb_rtc_field_write_seq;

    localparam logic [7:0] BASE  = 8'h00;
    localparam int         TB_TO = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] field_mask;
    logic [5:0] sel;
    logic [7:0] addr;
    logic       wr_req;
    logic       wr_ack;
    logic       busy;
    logic       done;
`ifdef RTC_WSEQ_TIMEOUT_EN
    logic       err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rtc_field_write_seq #(
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (TB_TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .field_mask (field_mask),
        .sel        (sel),
        .addr       (addr),
        .wr_req     (wr_req),
        .wr_ack     (wr_ack),
        .busy       (busy),
        .done       (done)
`ifdef RTC_WSEQ_TIMEOUT_EN
        ,
        .err        (err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: the ordered list of (sel, addr) writes follows directly from the mask; each
    // skipped field costs one cycle, each written field costs scan + settle + (delay+1) request cycles.
    task automatic run_seq(input logic [5:0] m, input int dly, input bit noise,
                           output int nwr, output int done_t);
        logic [5:0] q_sel[$];
        logic [7:0] q_addr[$];
        int         d[$];
        int         exp_t;
        int         hi;
        logic [5:0] s1;
        exp_t = 0;
        for (int i = 0; i < 6; i++) begin
            if (m[5-i]) begin
                s1 = 6'b100000;
                s1 = s1 >> i;
                q_sel.push_back(s1);
                q_addr.push_back(BASE + 8'(i));
                d.push_back(dly >= 0 ? dly : int'($urandom_range(0, 4)));
                exp_t += 3 + d[d.size()-1];
            end else begin
                exp_t += 1;
            end
        end
        start      = 1'b1;
        field_mask = m;
        @(posedge clk);
        #1;
        start      = 1'b0;
        field_mask = ~m;
        nwr    = 0;
        hi     = 0;
        done_t = -1;
        for (int t = 0; t < 300 && done_t < 0; t++) begin
            @(negedge clk);
            check("sel_onehot", 32'($onehot0(sel)), 32'd1);
            if (done) begin
                done_t = t;
                start  = 1'b0;
                wr_ack = 1'b0;
                check("done_busy", 32'(busy), 32'd0);
                check("done_sel", 32'(sel), 32'd0);
                check("done_wr_req", 32'(wr_req), 32'd0);
            end else begin
                check("busy_high", 32'(busy), 32'd1);
                if (wr_req) begin
                    if (nwr < q_sel.size()) begin
                        check("wr_sel", 32'(sel), 32'(q_sel[nwr]));
                        check("wr_addr", 32'(addr), 32'(q_addr[nwr]));
                        hi++;
                        if (hi == d[nwr] + 1) begin
                            wr_ack = 1'b1;
                            nwr++;
                            hi = 0;
                        end else begin
                            wr_ack = 1'b0;
                        end
                    end else begin
                        check("extra_write", 32'(nwr + 1), 32'(q_sel.size()));
                        wr_ack = 1'b1;
                    end
                end else begin
                    wr_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                end
                start      = noise && ($urandom_range(0, 3) == 0);
                field_mask = 6'($urandom);
            end
        end
        start  = 1'b0;
        wr_ack = 1'b0;
        if (done_t < 0) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("done_time", 32'(done_t), 32'(exp_t));
            check("num_writes", 32'(nwr), 32'(q_sel.size()));
            @(negedge clk);
            check("done_single", 32'(done), 32'd0);
            check("busy_after", 32'(busy), 32'd0);
        end
    endtask

    typedef struct {
        logic [5:0] mask;
        int         dly;
        bit         noise;
        int         exp_wr;
        int         exp_t;
    } vec_t;

    vec_t tbl[6];
    int   nwr;
    int   dt;
    int   hi;
    bit   seen;

    initial begin
        tbl[0] = '{6'b111111, 1, 1'b0, 6, 24};
        tbl[1] = '{6'b100001, 0, 1'b0, 2, 10};
        tbl[2] = '{6'b000000, 0, 1'b0, 0, 6};
        tbl[3] = '{6'b001000, 3, 1'b0, 1, 11};
        tbl[4] = '{6'b000001, 0, 1'b0, 1, 8};
        tbl[5] = '{6'b111111, 1, 1'b1, 6, 24};

        reset      = 1'b1;
        start      = 1'b0;
        wr_ack     = 1'b0;
        field_mask = 6'd0;
        repeat (3) @(negedge clk);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_addr", 32'(addr), 32'(BASE));
        check("rst_wr_req", 32'(wr_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef RTC_WSEQ_TIMEOUT_EN
        check("rst_err", 32'(err), 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_seq(tbl[i].mask, tbl[i].dly, tbl[i].noise, nwr, dt);
            check("tbl_writes", 32'(nwr), 32'(tbl[i].exp_wr));
            check("tbl_done_t", 32'(dt), 32'(tbl[i].exp_t));
        end

        for (int i = 0; i < 20; i++) begin
            run_seq(6'($urandom), -1, 1'b1, nwr, dt);
        end

        // Reset while the field C write is outstanding.
        start      = 1'b1;
        field_mask = 6'b001000;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen  = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (wr_req) seen = 1'b1;
        end
        check("mid_wr_req_seen", 32'(seen), 32'd1);
        check("mid_sel_c", 32'(sel), 32'(6'b001000));
        check("mid_addr_c", 32'(addr), 32'(BASE + 8'd2));
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_wr_req", 32'(wr_req), 32'd0);
        check("mid_rst_sel", 32'(sel), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_addr", 32'(addr), 32'(BASE));
        check("mid_rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        run_seq(6'b000100, 2, 1'b0, nwr, dt);
        check("post_rst_writes", 32'(nwr), 32'd1);

`ifdef RTC_WSEQ_TIMEOUT_EN
        // Withheld ack: the request must give up after TB_TO cycles and flag err.
        start      = 1'b1;
        field_mask = 6'b100000;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi    = 0;
        seen  = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            if (wr_req) hi++;
            if (done) begin
                seen = 1'b1;
                check("to_err", 32'(err), 32'd1);
            end
        end
        check("to_done_seen", 32'(seen), 32'd1);
        check("to_req_cycles", 32'(hi), 32'(TB_TO));
        @(negedge clk);
        check("to_err_sticky", 32'(err), 32'd1);
        start      = 1'b1;
        field_mask = 6'b000000;
        @(negedge clk);
        start = 1'b0;
        check("to_err_cleared", 32'(err), 32'd0);
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("to_next_done", 32'(seen), 32'd1);
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
